// File: rtl/instruction_memory_blk.sv
// instruction_memory_blk: block-read instruction memory with programmable latency, busywait handshake and byte program-load port
module instruction_memory_blk #(
  parameter  int BLOCK_BYTES = 16,
  parameter  int MEM_BYTES   = 1024,
  parameter  int LATENCY     = 5,
  localparam int OFF_W       = $clog2(BLOCK_BYTES),
  localparam int AW          = $clog2(MEM_BYTES),
  localparam int BA_W        = AW - OFF_W,
  localparam int CNT_W       = $clog2(LATENCY) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic [BA_W-1:0]          address,
  output logic [8*BLOCK_BYTES-1:0] readinst,
  output logic                     busywait,
  input  logic                     prog_we,
  input  logic [AW-1:0]            prog_addr,
  input  logic [7:0]               prog_data
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BA_W-1:0]          addr_q, addr_d;
  logic [8*BLOCK_BYTES-1:0] readinst_q, readinst_d, block;
  logic [7:0]               mem [MEM_BYTES];
  assign busywait = (state_q == IDLE && read) || state_q == BUSY;
  assign readinst = readinst_q;
  // gather every byte of the latched block so it can be loaded in one edge
  always_comb begin
    block = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) block[8*k +: 8] = mem[{addr_q, OFF_W'(k)}];
  end
  // next-state logic: capture request, count down latency, load block, spend one DONE cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    readinst_d = readinst_q;
    case (state_q)
      IDLE: if (read) begin
        addr_d  = address;
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = BUSY;
      end
      BUSY: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else begin
        readinst_d = block;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; a reset mid-access abandons it without touching memory
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      readinst_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      readinst_q <= readinst_d;
    end
  end
  // program-load writes only while idle with no request, so an access never sees a torn block
  always_ff @(posedge clock) begin
    if (!reset && prog_we && state_q == IDLE && !read) mem[prog_addr] <= prog_data;
  end
endmodule

// File: tb/tb_instruction_memory_blk.sv
// tb_instruction_memory_blk: randomized and directed checks of the block instruction memory against a cycle-count model
module tb_instruction_memory_blk;
  localparam int LAT = 5;
  logic clk = 0;
  always #5 clk = ~clk;
  logic         reset, read, prog_we;
  logic [5:0]   address;
  logic [127:0] readinst;
  logic         busywait;
  logic [9:0]   prog_addr;
  logic [7:0]   prog_data;
  logic         reset2, read2, prog_we2;
  logic [5:0]   address2;
  logic [31:0]  readinst2;
  logic         busywait2;
  logic [7:0]   prog_addr2, prog_data2;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  instruction_memory_blk dut (
    .clock(clk), .reset(reset), .read(read), .address(address), .readinst(readinst),
    .busywait(busywait), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );
  instruction_memory_blk #(.BLOCK_BYTES(4), .MEM_BYTES(256), .LATENCY(1)) dut2 (
    .clock(clk), .reset(reset2), .read(read2), .address(address2), .readinst(readinst2),
    .busywait(busywait2), .prog_we(prog_we2), .prog_addr(prog_addr2), .prog_data(prog_data2)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference memory image and transaction timing expressed in cycle numbers
  logic [7:0]   mm [1024];
  int           cyc = 0, st = -1;
  logic         m_busy, m_done, m_idle, exp_bw;
  logic [127:0] pend, exp_ri = '0;
  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = mm[{a, 4'(k)}];
    return r;
  endfunction
  function automatic logic [127:0] pblk(input int a);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'((a * 16 + k) * 7 + 3);
    return r;
  endfunction
  always @(negedge clk) begin
    m_busy = st >= 0 && cyc <= st + LAT;
    m_done = st >= 0 && cyc == st + LAT + 1;
    m_idle = !m_busy && !m_done;
    exp_bw = m_idle ? read : m_busy;
    if (chk_en) begin
      chk("busywait", 128'(busywait), 128'(exp_bw));
      chk("readinst", readinst, exp_ri);
    end
    if (reset) begin
      st = -1;
      exp_ri = '0;
    end else begin
      if (m_idle && read) begin
        st = cyc;
        pend = blk(address);
      end else if (m_idle && prog_we) mm[prog_addr] = prog_data;
      if (m_busy && cyc == st + LAT) exp_ri = pend;
      if (m_done) st = -1;
    end
    cyc++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic prog(input int a, input logic [7:0] d);
    prog_we = 1;
    prog_addr = 10'(a);
    prog_data = d;
    step();
    prog_we = 0;
  endtask
  task automatic wait_done(input int exp_n, input string nm);
    int n = 0;
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (busywait) n++;
      else ok = 1;
      if (!ok) begin
        step();
        prog_we = 0;
      end
    end
    chk({nm, " busy cycles"}, 128'(n), 128'(exp_n));
  endtask
  task automatic run_read(input int a, input bit hold, input string nm, output logic [127:0] ri);
    read = 1;
    address = 6'(a);
    wait_done(LAT + 1, nm);
    ri = readinst;
    step();
    read = hold;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [127:0] ri;
    logic [63:0]  w;
    int n;
    reset = 1; read = 0; address = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    reset2 = 1; read2 = 0; address2 = 0; prog_we2 = 0; prog_addr2 = 0; prog_data2 = 0;
    repeat (2) step();
    reset = 0; reset2 = 0; chk_en = 1;
    @(negedge clk);
    chk("reset busywait", 128'(busywait), 128'(0));
    chk("reset readinst", readinst, 128'(0));
    chk("reset2 busywait", 128'(busywait2), 128'(0));
    chk("reset2 readinst", 128'(readinst2), 128'(0));
    step();
    for (int i = 0; i < 1024; i++) prog(i, 8'($urandom));
    w = 64'h00050023_00040019;
    for (int i = 0; i < 8; i++) prog(i, w[8*i +: 8]);
    for (int i = 8; i < 96; i++) prog(i, 8'(i * 7 + 3));
    run_read(0, 0, "t1", ri);
    chk("t1 word0", 128'(ri[31:0]), 128'(32'h00040019));
    chk("t1 word1", 128'(ri[63:32]), 128'(32'h00050023));
    run_read(1, 1, "t2a", ri);
    chk("t2 block1", ri, pblk(1));
    run_read(2, 0, "t2b", ri);
    chk("t2 block2", ri, pblk(2));
    read = 1; address = 3;
    repeat (2) step();
    address = 5; read = 0;
    wait_done(LAT - 1, "t3");
    chk("t3 block3", readinst, pblk(3));
    step();
    read = 1; address = 0;
    repeat (3) step();
    reset = 1; read = 0;
    step();
    reset = 0;
    @(negedge clk);
    chk("t4 busywait", 128'(busywait), 128'(0));
    chk("t4 readinst", readinst, 128'(0));
    step();
    run_read(0, 0, "t4", ri);
    chk("t4 block0", 128'(ri[63:0]), 128'(64'h00050023_00040019));
    prog_we = 1; prog_addr = 16; prog_data = 8'hFF;
    run_read(1, 0, "t5a", ri);
    chk("t5 dropped write", 128'(ri[7:0]), 128'(8'h73));
    prog(17, 8'hA5);
    run_read(1, 0, "t5b", ri);
    chk("t5 loaded byte", 128'(ri[15:8]), 128'(8'hA5));
    run_read(63, 0, "top", ri);
    chk("top block", ri, blk(6'd63));
    for (int i = 0; i < 3000; i++) begin
      read = $urandom_range(0, 1) == 1;
      address = 6'($urandom);
      prog_we = $urandom_range(0, 1) == 1;
      prog_addr = 10'($urandom);
      prog_data = 8'($urandom);
      reset = $urandom_range(0, 49) == 0;
      step();
    end
    read = 0; prog_we = 0; reset = 0;
    repeat (10) step();
    for (int i = 0; i < 4; i++) begin
      prog_we2 = 1;
      prog_addr2 = 8'(252 + i);
      prog_data2 = 8'(8'h11 * (i + 1));
      step();
    end
    prog_we2 = 0;
    read2 = 1; address2 = 63;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busywait2) break;
      n++;
      step();
    end
    chk("t6 busy cycles", 128'(n), 128'(2));
    chk("t6 block63", 128'(readinst2), 128'(32'h44332211));
    step();
    read2 = 0;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
